// File: rtl/micro_sequencer_if.sv
// Sequencing bus between the microstore fields and the next-state controller.
// The master drives the microinstruction fields and status inputs; the slave returns the state.
interface micro_sequencer_if #(
  parameter int STATE_W = 7
);
  logic [2:0]         next_sel;
  logic [1:0]         cond_sel;
  logic               inv;
  logic [STATE_W-1:0] cr;
  logic [STATE_W-1:0] enc_state;
  logic               moc;
  logic               cond;
  logic               irq;
  logic [STATE_W-1:0] state;
  logic               waiting;
  logic               mem_timeout;
  logic               illegal_state;

  modport master (
    output next_sel, cond_sel, inv, cr, enc_state, moc, cond, irq,
    input  state, waiting, mem_timeout, illegal_state
  );

  modport slave (
    input  next_sel, cond_sel, inv, cr, enc_state, moc, cond, irq,
    output state, waiting, mem_timeout, illegal_state
  );
endinterface

// File: rtl/micro_sequencer.sv
// Next-state controller for the microprogrammed control unit: holds the microstore
// address and selects the next one from the sequencing fields, with a memory-wait watchdog.
//
// next_sel | meaning
// 000      | encoder: go to enc_state
// 001      | fetch: go to FETCH_STATE
// 010      | jump: go to cr
// 011      | increment: state+1 (wraps)
// 100      | c ? cr : state+1
// 101      | c ? cr : enc_state
// 110      | c ? state+1 : hold and count wait cycles
// 111      | hold, no wait counting
module micro_sequencer #(
  parameter int                 STATE_W     = 7,
  parameter logic [STATE_W-1:0] FETCH_STATE = '0,
  parameter logic [STATE_W-1:0] MAX_STATE   = STATE_W'(23),
  parameter logic [STATE_W-1:0] ERR_STATE   = '0,
  parameter int                 TIMEOUT     = 15,
  parameter int                 TO_W        = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  micro_sequencer_if.slave      bus
);

  typedef enum logic [2:0] {
    SEL_ENC    = 3'b000,
    SEL_FETCH  = 3'b001,
    SEL_JUMP   = 3'b010,
    SEL_INC    = 3'b011,
    SEL_BR_INC = 3'b100,
    SEL_BR_ENC = 3'b101,
    SEL_WAIT   = 3'b110,
    SEL_HOLD   = 3'b111
  } sel_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  sel_e               sel;
  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] target, state_inc;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               illegal_q, illegal_d;
  logic               cond_src, c, wait_hold;

  assign sel       = sel_e'(bus.next_sel);
  assign state_inc = state_q + STATE_W'(1);

  always_comb begin
    cond_src = 1'b0;
    case (bus.cond_sel)
      2'b00:   cond_src = bus.moc;
      2'b01:   cond_src = bus.cond;
      2'b10:   cond_src = 1'b1;
      default: cond_src = bus.irq;
    endcase
  end

  assign c = cond_src ^ bus.inv;

  always_comb begin
    target    = state_q;
    wait_hold = 1'b0;
    case (sel)
      SEL_ENC:    target = bus.enc_state;
      SEL_FETCH:  target = FETCH_STATE;
      SEL_JUMP:   target = bus.cr;
      SEL_INC:    target = state_inc;
      SEL_BR_INC: target = c ? bus.cr : state_inc;
      SEL_BR_ENC: target = c ? bus.cr : bus.enc_state;
      SEL_WAIT: begin
        if (c) target = state_inc;
        else   wait_hold = 1'b1;
      end
      SEL_HOLD:   target = state_q;
      default:    target = state_q;
    endcase

    // Watchdog expiry outranks the range check; a hold target is always legal anyway.
    timeout_d = wait_hold && (cnt_q == TO_LAST);
    illegal_d = (target > MAX_STATE) && !timeout_d;

    cnt_d = '0;
    if (wait_hold && !timeout_d) cnt_d = cnt_q + TO_W'(1);

    state_d = target;
    if (timeout_d)      state_d = ERR_STATE;
    else if (illegal_d) state_d = FETCH_STATE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= FETCH_STATE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      illegal_q <= illegal_d;
    end
  end

  // Inputs are don't-care in reset, so waiting is masked there.
  assign bus.state         = state_q;
  assign bus.waiting       = wait_hold & rst_n_i;
  assign bus.mem_timeout   = timeout_q;
  assign bus.illegal_state = illegal_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: expected {state, illegal, timeout} tuples are queued
// when a cycle's inputs are driven and compared one time unit after the following edge.
module tb_micro_sequencer;
  localparam int SW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  micro_sequencer_if #(.STATE_W(SW)) bus ();

  micro_sequencer #(
    .STATE_W(SW), .FETCH_STATE(7'd0), .MAX_STATE(7'd23),
    .ERR_STATE(7'd0), .TIMEOUT(15), .TO_W(4)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus.slave)
  );

  typedef struct packed {
    logic [SW-1:0] st;
    logic          ill;
    logic          to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input logic [2:0] ns, input logic [1:0] cs, input logic iv,
                       input logic [SW-1:0] cr_v, input logic [SW-1:0] enc_v,
                       input logic m, input logic cd, input logic ir);
    bus.next_sel  = ns;
    bus.cond_sel  = cs;
    bus.inv       = iv;
    bus.cr        = cr_v;
    bus.enc_state = enc_v;
    bus.moc       = m;
    bus.cond      = cd;
    bus.irq       = ir;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input logic [SW-1:0] s);
    drive(3'b010, 2'b00, 1'b0, s, 7'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    exp_t e, o;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(3'b110, 2'b00, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
      else drive(3'($urandom), 2'($urandom), 1'($urandom), 7'($urandom), 7'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      checks++;
      if (bus.waiting !== 1'b0) begin
        errors++;
        $display("FAIL reset_waiting[%0d]: got %b expected 0", i, bus.waiting);
      end
      sb.push_back('{st: 7'd0, ill: 1'b0, to: 1'b0});
      tick();
      e = sb.pop_front();
      o = '{st: bus.state, ill: bus.illegal_state, to: bus.mem_timeout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got st=%0d ill=%b to=%b expected st=%0d ill=%b to=%b",
                 i, o.st, o.ill, o.to, e.st, e.ill, e.to);
      end
    end
    drive(3'b011, 2'b00, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    sb.push_back('{st: 7'd1, ill: 1'b0, to: 1'b0});
    tick();
    e = sb.pop_front();
    o = '{st: bus.state, ill: bus.illegal_state, to: bus.mem_timeout};
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_release: got st=%0d ill=%b to=%b expected st=%0d ill=%b to=%b",
               o.st, o.ill, o.to, e.st, e.ill, e.to);
    end
  endtask

  typedef struct packed {
    logic [2:0]    ns;
    logic [1:0]    cs;
    logic          iv;
    logic          m;
    logic          cd;
    logic          ir;
    logic [SW-1:0] exp;
  } mode_t;

  task automatic test_modes();
    mode_t tbl[$];
    exp_t  e, o;
    tbl.push_back('{ns: 3'b000, cs: 2'b00, iv: 1'b0, m: 1'b0, cd: 1'b0, ir: 1'b0, exp: 7'd6});
    tbl.push_back('{ns: 3'b001, cs: 2'b00, iv: 1'b0, m: 1'b0, cd: 1'b0, ir: 1'b0, exp: 7'd0});
    tbl.push_back('{ns: 3'b010, cs: 2'b00, iv: 1'b0, m: 1'b0, cd: 1'b0, ir: 1'b0, exp: 7'd10});
    tbl.push_back('{ns: 3'b011, cs: 2'b00, iv: 1'b0, m: 1'b0, cd: 1'b0, ir: 1'b0, exp: 7'd4});
    tbl.push_back('{ns: 3'b100, cs: 2'b01, iv: 1'b0, m: 1'b0, cd: 1'b1, ir: 1'b0, exp: 7'd10});
    tbl.push_back('{ns: 3'b100, cs: 2'b01, iv: 1'b1, m: 1'b0, cd: 1'b1, ir: 1'b0, exp: 7'd4});
    tbl.push_back('{ns: 3'b100, cs: 2'b00, iv: 1'b0, m: 1'b1, cd: 1'b0, ir: 1'b0, exp: 7'd10});
    tbl.push_back('{ns: 3'b101, cs: 2'b01, iv: 1'b0, m: 1'b0, cd: 1'b0, ir: 1'b0, exp: 7'd6});
    tbl.push_back('{ns: 3'b101, cs: 2'b11, iv: 1'b0, m: 1'b0, cd: 1'b0, ir: 1'b1, exp: 7'd10});
    tbl.push_back('{ns: 3'b101, cs: 2'b11, iv: 1'b1, m: 1'b0, cd: 1'b0, ir: 1'b1, exp: 7'd6});
    tbl.push_back('{ns: 3'b110, cs: 2'b10, iv: 1'b0, m: 1'b0, cd: 1'b0, ir: 1'b0, exp: 7'd4});
    tbl.push_back('{ns: 3'b111, cs: 2'b10, iv: 1'b0, m: 1'b1, cd: 1'b1, ir: 1'b1, exp: 7'd3});
    foreach (tbl[i]) begin
      goto(7'd3);
      drive(tbl[i].ns, tbl[i].cs, tbl[i].iv, 7'd10, 7'd6, tbl[i].m, tbl[i].cd, tbl[i].ir);
      sb.push_back('{st: tbl[i].exp, ill: 1'b0, to: 1'b0});
      tick();
      e = sb.pop_front();
      o = '{st: bus.state, ill: bus.illegal_state, to: bus.mem_timeout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mode[%0d] sel=%b: got st=%0d ill=%b to=%b expected st=%0d ill=%b to=%b",
                 i, tbl[i].ns, o.st, o.ill, o.to, e.st, e.ill, e.to);
      end
    end
  endtask

  task automatic test_moc_wait();
    exp_t e, o;
    goto(7'd2);
    for (int i = 0; i < 5; i++) begin
      drive(3'b110, 2'b00, 1'b0, 7'd0, 7'd0, (i == 4), 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.waiting !== (i != 4)) begin
        errors++;
        $display("FAIL moc_waiting[%0d]: got %b expected %b", i, bus.waiting, (i != 4));
      end
      sb.push_back('{st: (i == 4) ? 7'd3 : 7'd2, ill: 1'b0, to: 1'b0});
      tick();
      e = sb.pop_front();
      o = '{st: bus.state, ill: bus.illegal_state, to: bus.mem_timeout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL moc_wait[%0d]: got st=%0d ill=%b to=%b expected st=%0d ill=%b to=%b",
                 i, o.st, o.ill, o.to, e.st, e.ill, e.to);
      end
    end
  endtask

  // Run 0 holds moc low to expiry; run 1 raises moc in the 15th waiting cycle.
  task automatic test_timeout();
    exp_t e, o;
    for (int run = 0; run < 2; run++) begin
      goto(7'd2);
      for (int i = 0; i < 16; i++) begin
        if (i < 15) begin
          drive(3'b110, 2'b00, 1'b0, 7'd0, 7'd0, (run == 1 && i == 14), 1'b0, 1'b0);
          if (i < 14)         sb.push_back('{st: 7'd2, ill: 1'b0, to: 1'b0});
          else if (run == 0)  sb.push_back('{st: 7'd0, ill: 1'b0, to: 1'b1});
          else                sb.push_back('{st: 7'd3, ill: 1'b0, to: 1'b0});
        end else begin
          drive(3'b111, 2'b00, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
          sb.push_back('{st: (run == 0) ? 7'd0 : 7'd3, ill: 1'b0, to: 1'b0});
        end
        tick();
        e = sb.pop_front();
        o = '{st: bus.state, ill: bus.illegal_state, to: bus.mem_timeout};
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL timeout run%0d[%0d]: got st=%0d ill=%b to=%b expected st=%0d ill=%b to=%b",
                   run, i, o.st, o.ill, o.to, e.st, e.ill, e.to);
        end
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e, o;
    logic [SW-1:0] start[3] = '{7'd5, 7'd23, 7'd22};
    logic [2:0]    ns[3]    = '{3'b010, 3'b011, 3'b011};
    logic [SW-1:0] dest[3]  = '{7'd0, 7'd0, 7'd23};
    logic          ill[3]   = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      goto(start[k]);
      for (int j = 0; j < 2; j++) begin
        if (j == 0) begin
          drive(ns[k], 2'b00, 1'b0, 7'd40, 7'd0, 1'b0, 1'b0, 1'b0);
          sb.push_back('{st: dest[k], ill: ill[k], to: 1'b0});
        end else begin
          drive(3'b111, 2'b00, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
          sb.push_back('{st: dest[k], ill: 1'b0, to: 1'b0});
        end
        tick();
        e = sb.pop_front();
        o = '{st: bus.state, ill: bus.illegal_state, to: bus.mem_timeout};
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL illegal[%0d.%0d]: got st=%0d ill=%b to=%b expected st=%0d ill=%b to=%b",
                   k, j, o.st, o.ill, o.to, e.st, e.ill, e.to);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e, o;
    goto(7'd2);
    drive(3'b110, 2'b00, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    repeat (7) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== 7'd0 || bus.waiting !== 1'b0 || bus.mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got st=%0d wait=%b to=%b expected st=0 wait=0 to=0",
               bus.state, bus.waiting, bus.mem_timeout);
    end
    tick();
    rst_n = 1'b1;
    // State 0 is both the wait point and ERR_STATE, so only the pulse timing shows the count.
    for (int i = 0; i < 16; i++) begin
      if (i < 15) drive(3'b110, 2'b00, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
      else        drive(3'b111, 2'b00, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
      sb.push_back('{st: 7'd0, ill: 1'b0, to: (i == 14)});
      tick();
      e = sb.pop_front();
      o = '{st: bus.state, ill: bus.illegal_state, to: bus.mem_timeout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL post_reset_wait[%0d]: got st=%0d ill=%b to=%b expected st=%0d ill=%b to=%b",
                 i, o.st, o.ill, o.to, e.st, e.ill, e.to);
      end
    end
  endtask

  initial begin
    drive(3'b000, 2'b00, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_modes();
    test_moc_wait();
    test_timeout();
    test_illegal();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "time limit reached");
  end

endmodule
